muldiv_seq: RTL

//   Multi-cycle multiply/divide sequencer that owns the HI/LO result pair behind the ALU MUL/DIV/MFHI ops.

---
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer that owns the HI/LO result pair.
// Each operation iterates one bit per cycle for N cycles. Multiply uses shift-add and divide
// uses restoring division. HI/LO are then committed atomically together with a one-cycle done pulse.
// Optional feature macro: MULDIV_SIGNED_EN. When it is defined, i_sgn=1 selects two's-complement
// operands. When it is undefined, i_sgn is ignored.
module muldiv_seq #(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_op_div,
  input  logic         i_sgn,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div_by_zero,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          r_state, w_state_nx;
  logic [CntW-1:0] r_cnt;
  logic [N-1:0]    r_acc;    // MUL: upper partial product; DIV: partial remainder
  logic [N-1:0]    r_mq;     // MUL: multiplier -> lower product; DIV: dividend -> quotient
  logic [N-1:0]    r_opd;    // MUL: multiplicand; DIV: divisor
  logic [N-1:0]    r_hi, r_lo;
  logic            r_op_div, r_y_zero, r_dbz;

  logic            w_accept, w_last;
  logic [N-1:0]    w_x_mag, w_y_mag;
  logic [N-1:0]    w_acc_nx, w_mq_nx;
  logic [N-1:0]    w_hi_fin, w_lo_fin;
  logic [N:0]      w_sum, w_shift;
  logic [N-1:0]    w_diff;
  logic            w_ge;

  // FIN also accepts a new op, which gives a zero-bubble restart
  assign w_accept = i_start && (r_state != StRun);
  assign w_last   = (r_cnt == CntW'(N - 1));

`ifdef MULDIV_SIGNED_EN
  logic r_neg_a;  // MUL: negate full product; DIV: negate quotient
  logic r_neg_b;  // DIV: negate remainder (follows dividend sign)
  logic w_x_neg, w_y_neg;
  assign w_x_neg = i_sgn & i_x[N-1];
  assign w_y_neg = i_sgn & i_y[N-1];
  assign w_x_mag = w_x_neg ? -i_x : i_x;
  assign w_y_mag = w_y_neg ? -i_y : i_y;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = i_sgn;
  assign w_x_mag      = i_x;
  assign w_y_mag      = i_y;
`endif

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_opd : {N{1'b0}})};
    w_shift = {r_acc, r_mq[N-1]};
    w_ge    = (w_shift >= {1'b0, r_opd});
    w_diff  = w_shift[N-1:0] - r_opd;
    if (r_op_div) begin
      w_acc_nx = w_ge ? w_diff : w_shift[N-1:0];
      w_mq_nx  = {r_mq[N-2:0], w_ge};
    end else begin
      w_acc_nx = w_sum[N:1];
      w_mq_nx  = {w_sum[0], r_mq[N-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic [2*N-1:0] w_prod;
  assign w_prod = {w_acc_nx, w_mq_nx};

  // Sign fix-up of the final iteration result, applied on the commit edge
  always_comb begin
    {w_hi_fin, w_lo_fin} = w_prod;
    if (!r_op_div) begin
      if (r_neg_a) {w_hi_fin, w_lo_fin} = -w_prod;
    end else begin
      if (r_neg_a) w_lo_fin = -w_mq_nx;
      if (r_neg_b) w_hi_fin = -w_acc_nx;
    end
  end
`else
  assign w_hi_fin = w_acc_nx;
  assign w_lo_fin = w_mq_nx;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nx = StRun;
      StRun:   if (w_last) w_state_nx = StFin;
      StFin:   w_state_nx = i_start ? StRun : StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // Datapath: capture operands on accept, iterate in RUN, and commit HI/LO on the last iteration
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_opd    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op_div <= 1'b0;
      r_y_zero <= 1'b0;
      r_dbz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
`endif
    end else begin
      r_dbz <= 1'b0;
      if (w_accept) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_op_div <= i_op_div;
        r_y_zero <= (i_y == '0);
        r_mq     <= i_op_div ? w_x_mag : w_y_mag;
        r_opd    <= i_op_div ? w_y_mag : w_x_mag;
`ifdef MULDIV_SIGNED_EN
        // A zero divisor keeps the quotient all-ones, so it is never negated
        r_neg_a  <= (w_x_neg ^ w_y_neg) & ~(i_op_div & (i_y == '0));
        r_neg_b  <= i_op_div & w_x_neg;
`endif
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt + CntW'(1);
        r_acc <= w_acc_nx;
        r_mq  <= w_mq_nx;
        if (w_last) begin
          r_hi  <= w_hi_fin;
          r_lo  <= w_lo_fin;
          r_dbz <= r_op_div & r_y_zero;
        end
      end
    end
  end

  assign o_busy        = (r_state == StRun);
  assign o_done        = (r_state == StFin);
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
